timer_dev: RTL and testbench

- Memory-mapped countdown timer. It is the responder on the processor-bridge bus that the pipelined CPU drives through PrAddr, PrWD, PrBE and PrWE, reading back PrRD.
- Sits behind the bridge. The bridge decodes the device select and routes this block's irq onto one HWInt line.
- Three software-visible registers: CTRL, PRESET, COUNT. Counts down from PRESET and raises an interrupt at zero, in one-shot or auto-reload mode.

---
 rtl/timer_pkg.sv | 38 +++
 rtl/timer_prescaler.sv | 27 ++
 rtl/timer_dev.sv | 129 ++++++++++++
 tb/tb_timer_dev.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer_dev countdown timer: FSM encoding, register map, CTRL layout.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;

    localparam int unsigned PRESCALE_W = 16;

    // Replace only the byte lanes selected by be.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] r_res;
        r_res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r_res[8*i +: 8] = new_val[8*i +: 8];
        end
        return r_res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter for timer_dev: pulses o_tick_c once every (i_prescale+1) running cycles.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_run,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tick_c
);

    logic [PRESCALE_W-1:0] r_cnt;

    // >= keeps the counter from running away if PRESCALE is lowered mid-count.
    assign o_tick_c = i_run && (r_cnt >= i_prescale);

    always_ff @(posedge clk) begin
        if (reset || !i_run) begin
            r_cnt <= '0;
        end else if (o_tick_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot and auto-reload modes.
// Define TIMER_PRESCALE_EN to make offset 0xC a 16-bit PRESCALE register.
module timer_dev
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t           r_state;
    logic [3:0]       r_ctrl;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] r_count;
    logic             r_irq_flag;

    logic w_wr_ctrl;
    logic w_wr_preset;
    logic w_en;
    logic w_reload;
    logic w_tick;

    assign w_wr_ctrl   = sel && we && (addr == OFF_CTRL);
    assign w_wr_preset = sel && we && (addr == OFF_PRESET);
    assign w_en        = r_ctrl[CTRL_EN];
    assign w_reload    = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

    // Flop-only path: no bus signal reaches irq combinationally.
    assign irq = r_ctrl[CTRL_IM] & r_irq_flag;

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] r_prescale;

    timer_prescaler u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .i_run      ((r_state == ST_CNT) && w_en),
        .i_prescale (r_prescale),
        .o_tick_c   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescale <= '0;
        end else if (sel && we && (addr == OFF_RSVD)) begin
            r_prescale <= PRESCALE_W'(merge_bytes(32'(r_prescale), wdata, be));
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // Zero-wait-state read mux, independent of sel/we.
    always_comb begin
        rdata = '0;
        unique case (addr)
            OFF_CTRL:   rdata = 32'(r_ctrl);
            OFF_PRESET: rdata = 32'(r_preset);
            OFF_COUNT:  rdata = 32'(r_count);
`ifdef TIMER_PRESCALE_EN
            OFF_RSVD:   rdata = 32'(r_prescale);
`else
            OFF_RSVD:   rdata = '0;
`endif
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            // Software acknowledge; an FSM set on the same edge below takes precedence.
            if ((w_wr_ctrl || w_wr_preset) && (|be)) r_irq_flag <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_en) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!w_en) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_preset;
                        r_state <= ST_CNT;
                    end
                end
                ST_CNT: begin
                    if (!w_en) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        if (r_count > CNT_W'(1)) begin
                            r_count <= r_count - CNT_W'(1);
                        end else begin
                            r_count    <= '0;
                            r_irq_flag <= 1'b1;
                            r_state    <= ST_INT;
                            if (!w_reload) r_ctrl[CTRL_EN] <= 1'b0;
                        end
                    end
                end
                ST_INT: begin
                    if (w_reload) begin
                        r_irq_flag <= 1'b0;
                        r_state    <= w_en ? ST_LOAD : ST_IDLE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase

            // Bus writes come last so they override the FSM's EN clear.
            if (w_wr_ctrl && be[0]) r_ctrl <= wdata[3:0];
            if (w_wr_preset) r_preset <= CNT_W'(merge_bytes(32'(r_preset), wdata, be));
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev; the prescale test runs only with TIMER_PRESCALE_EN.
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks;
    int n_fail;

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 2ns after each rising edge.
    task automatic wait_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
        wait_edge();
        sel = 1'b0; we = 1'b0; be = 4'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_edge();
        wait_edge();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), v);
            n_checks++;
            if (v !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read off=%0d got=%h exp=%h", i, v, 32'h0);
            end
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'd3, 4'hF);
        bus_write(2'd0, 32'h9, 4'hF);        // edge t
        wait_edge();                          // t+1 (LOAD)
        for (int k = 0; k < 4; k++) begin
            wait_edge();                      // t+2+k
            bus_read(2'd2, v);
            n_checks++;
            if (v !== 32'(3 - k)) begin
                n_fail++;
                $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, v, 3 - k);
            end
            n_checks++;
            if (irq !== (k == 3)) begin
                n_fail++;
                $display("FAIL oneshot_irq k=%0d got=%b exp=%b", k, irq, (k == 3));
            end
        end
        wait_edge();
        wait_edge();
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_irq_held got=%b exp=1", irq);
        end
        bus_read(2'd0, v);
        n_checks++;
        if (v !== 32'h8) begin
            n_fail++;
            $display("FAIL oneshot_ctrl got=%h exp=%h", v, 32'h8);
        end
        bus_write(2'd0, 32'h8, 4'hF);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_ack got=%b exp=0", irq);
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        logic [31:0] exp_cnt [4];
        logic        exp_irq [4];
        exp_cnt[0] = 32'd2; exp_cnt[1] = 32'd1; exp_cnt[2] = 32'd0; exp_cnt[3] = 32'd0;
        exp_irq[0] = 1'b0;  exp_irq[1] = 1'b0;  exp_irq[2] = 1'b1;  exp_irq[3] = 1'b0;
        do_reset();
        bus_write(2'd1, 32'd2, 4'hF);
        bus_write(2'd0, 32'hB, 4'hF);        // edge t
        wait_edge();                          // t+1
        for (int k = 0; k < 12; k++) begin
            wait_edge();                      // t+2+k
            bus_read(2'd2, v);
            n_checks++;
            if (v !== exp_cnt[k % 4]) begin
                n_fail++;
                $display("FAIL reload_count k=%0d got=%0d exp=%0d", k, v, exp_cnt[k % 4]);
            end
            n_checks++;
            if (irq !== exp_irq[k % 4]) begin
                n_fail++;
                $display("FAIL reload_irq k=%0d got=%b exp=%b", k, irq, exp_irq[k % 4]);
            end
        end
    endtask

    task automatic test_stop_midcount();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'd9, 4'hF);
        bus_write(2'd0, 32'h9, 4'hF);        // edge t
        wait_edge();
        for (int k = 0; k < 4; k++) wait_edge();   // t+5, COUNT=6
        bus_write(2'd0, 32'h8, 4'hF);        // commits at t+6 while COUNT becomes 5
        for (int k = 0; k < 3; k++) begin
            wait_edge();
            bus_read(2'd2, v);
            n_checks++;
            if (v !== 32'd5) begin
                n_fail++;
                $display("FAIL stop_count k=%0d got=%0d exp=5", k, v);
            end
            n_checks++;
            if (irq !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_irq k=%0d got=%b exp=0", k, irq);
            end
        end
        bus_write(2'd0, 32'h9, 4'hF);        // edge u
        wait_edge();
        wait_edge();                          // u+2
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 32'd9) begin
            n_fail++;
            $display("FAIL restart_reload got=%0d exp=9", v);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'hAABBCCDD, 4'b0010);
        bus_read(2'd1, v);
        n_checks++;
        if (v !== 32'h0000CC00) begin
            n_fail++;
            $display("FAIL preset_lane1 got=%h exp=%h", v, 32'h0000CC00);
        end
        bus_write(2'd1, 32'hAABBCCDD, 4'b1000);
        bus_read(2'd1, v);
        n_checks++;
        if (v !== 32'hAA00CC00) begin
            n_fail++;
            $display("FAIL preset_lane3 got=%h exp=%h", v, 32'hAA00CC00);
        end
        bus_write(2'd1, 32'h0000CC00, 4'hF);
        bus_write(2'd0, 32'h1, 4'hF);        // edge t
        wait_edge();                          // t+1
        wait_edge();                          // t+2, COUNT=0xCC00
        bus_write(2'd0, 32'h0, 4'hF);        // t+3: last decrement, EN cleared
        wait_edge();                          // t+4 IDLE
        bus_write(2'd2, 32'hFFFFFFFF, 4'hF);
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 32'h0000CBFF) begin
            n_fail++;
            $display("FAIL count_readonly got=%h exp=%h", v, 32'h0000CBFF);
        end
`ifndef TIMER_PRESCALE_EN
        bus_write(2'd3, 32'h12345678, 4'hF);
        bus_read(2'd3, v);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL reserved_read got=%h exp=0", v);
        end
`endif
    endtask

    task automatic test_preset_zero();
        logic [31:0] v;
        do_reset();
        bus_write(2'd0, 32'h9, 4'hF);        // edge t, PRESET=0
        wait_edge();
        wait_edge();                          // t+2
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL preset0_early got=%b exp=0", irq);
        end
        wait_edge();                          // t+3
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL preset0_irq got=%b exp=1", irq);
        end
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL preset0_count got=%h exp=0", v);
        end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'd10, 4'hF);
        bus_write(2'd0, 32'h9, 4'hF);        // edge t
        wait_edge();
        for (int k = 0; k < 4; k++) wait_edge();   // t+5, COUNT=7
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 32'd7) begin
            n_fail++;
            $display("FAIL midreset_pre got=%0d exp=7", v);
        end
        reset = 1'b1;
        wait_edge();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), v);
            n_checks++;
            if (v !== 32'h0) begin
                n_fail++;
                $display("FAIL midreset_read off=%0d got=%h exp=0", i, v);
            end
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_irq got=%b exp=0", irq);
        end
        wait_edge();
        wait_edge();
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_idle got=%h exp=0", v);
        end
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale();
        logic [31:0] v;
        logic [31:0] exp_cnt [7];
        exp_cnt[0] = 32'd2; exp_cnt[1] = 32'd2; exp_cnt[2] = 32'd2;
        exp_cnt[3] = 32'd1; exp_cnt[4] = 32'd1; exp_cnt[5] = 32'd1; exp_cnt[6] = 32'd0;
        do_reset();
        bus_write(2'd3, 32'hFFFF0002, 4'hF);
        bus_read(2'd3, v);
        n_checks++;
        if (v !== 32'h2) begin
            n_fail++;
            $display("FAIL prescale_read got=%h exp=2", v);
        end
        bus_write(2'd1, 32'd2, 4'hF);
        bus_write(2'd0, 32'h9, 4'hF);        // edge t
        wait_edge();
        for (int k = 0; k < 7; k++) begin
            wait_edge();                      // t+2+k
            bus_read(2'd2, v);
            n_checks++;
            if (v !== exp_cnt[k]) begin
                n_fail++;
                $display("FAIL prescale_count k=%0d got=%0d exp=%0d", k, v, exp_cnt[k]);
            end
        end
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL prescale_irq got=%b exp=1", irq);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; be = 4'h0; wdata = 32'h0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_stop_midcount();
        test_byte_lanes();
        test_preset_zero();
        test_reset_midcount();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
